// File: rtl/bsg_fsb_traffic_node.sv
// FSB traffic node: runtime-selectable loopback echo, packet generator and packet checker on one FSB port.
// Define BSG_FSB_TRAFFIC_NODE_LFSR_EN to scramble the low 16 payload bits with a 16-bit LFSR.

module bsg_fsb_traffic_node #(
  parameter int         ring_width_p      = 80,
  parameter logic [3:0] client_id_p       = 4'd0,
  parameter int         fifo_els_p        = 4,
  parameter int         pkt_count_width_p = 16
) (
  input  logic                         clk_i,
  input  logic                         async_reset_n_i,
  input  logic                         en_i,
  input  logic [1:0]                   mode_i,
  input  logic [pkt_count_width_p-1:0] num_pkts_i,
  input  logic                         v_i,
  input  logic [ring_width_p-1:0]      data_i,
  output logic                         ready_o,
  output logic                         v_o,
  output logic [ring_width_p-1:0]      data_o,
  input  logic                         yumi_i,
  output logic [pkt_count_width_p-1:0] sent_count_o,
  output logic [pkt_count_width_p-1:0] recv_count_o,
  output logic [pkt_count_width_p-1:0] error_count_o,
  output logic                         error_o,
  output logic                         done_o
);

  localparam int payload_w_lp = ring_width_p - 4;
  localparam int ptr_w_lp     = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w_lp     = $clog2(fifo_els_p + 1);

  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(fifo_els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(fifo_els_p);

  localparam logic [1:0] mode_loop_lp  = 2'd1;
  localparam logic [1:0] mode_gen_lp   = 2'd2;
  localparam logic [1:0] mode_check_lp = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [1:0]                     mode_q, mode_d;
  logic [pkt_count_width_p-1:0]   num_q, num_d;
  logic [pkt_count_width_p-1:0]   sent_q, sent_d;
  logic [pkt_count_width_p-1:0]   recv_q, recv_d;
  logic [pkt_count_width_p-1:0]   err_cnt_q, err_cnt_d;
  logic                           error_q, error_d;
  logic [pkt_count_width_p-1:0]   seq_q, seq_d;
  logic                           gen_v_q, gen_v_d;
`ifdef BSG_FSB_TRAFFIC_NODE_LFSR_EN
  logic [15:0]                    lfsr_q, lfsr_d;
`endif

  logic [ring_width_p-1:0]        mem_q [fifo_els_p];
  logic [ptr_w_lp-1:0]            wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0]            rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]            fifo_cnt_q, fifo_cnt_d;

  logic                           run, is_loop, is_gen, is_check;
  logic                           fifo_full, fifo_empty, loop_v;
  logic                           in_fire, out_fire, seq_step, mismatch;
  logic                           fifo_enq, fifo_deq;
  logic [payload_w_lp-1:0]        seq_payload;
  logic [pkt_count_width_p-1:0]   gov_count;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    seq_payload = '0;
    seq_payload[pkt_count_width_p-1:0] = seq_q;
`ifdef BSG_FSB_TRAFFIC_NODE_LFSR_EN
    seq_payload[15:0] = seq_payload[15:0] ^ lfsr_q;
`endif
  end

  always_comb begin
    run        = (state_q == RUN);
    is_loop    = (mode_q == mode_loop_lp);
    is_gen     = (mode_q == mode_gen_lp);
    is_check   = (mode_q == mode_check_lp);
    fifo_full  = (fifo_cnt_q == full_cnt_lp);
    fifo_empty = (fifo_cnt_q == '0);
    loop_v     = run && is_loop && !fifo_empty;

    ready_o = run && (!is_loop || !fifo_full);
    v_o     = loop_v || gen_v_q;
    data_o  = '0;
    if (loop_v) begin
      data_o = mem_q[rd_ptr_q];
    end else if (gen_v_q) begin
      data_o = {client_id_p, seq_payload};
    end

    in_fire  = v_i && ready_o;
    out_fire = v_o && yumi_i;
    seq_step = (is_gen && out_fire) || (is_check && in_fire);
    mismatch = (data_i[payload_w_lp-1:0] != seq_payload);
  end

  // Mode and packet count are only sampled on the IDLE->RUN edge.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    num_d     = num_q;
    sent_d    = sent_q;
    recv_d    = recv_q;
    err_cnt_d = err_cnt_q;
    error_d   = error_q;
    seq_d     = seq_q;
`ifdef BSG_FSB_TRAFFIC_NODE_LFSR_EN
    lfsr_d    = lfsr_q;
`endif

    if (out_fire) sent_d = sent_q + 1'b1;
    if (in_fire)  recv_d = recv_q + 1'b1;

    if (seq_step) begin
      seq_d = seq_q + 1'b1;
`ifdef BSG_FSB_TRAFFIC_NODE_LFSR_EN
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
    end

    if (is_check && in_fire && mismatch) begin
      error_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
    end

    gov_count = is_check ? recv_d : sent_d;

    case (state_q)
      IDLE: begin
        if (en_i && (mode_i != 2'd0)) begin
          state_d   = RUN;
          mode_d    = mode_i;
          num_d     = num_pkts_i;
          sent_d    = '0;
          recv_d    = '0;
          err_cnt_d = '0;
          error_d   = 1'b0;
          seq_d     = '0;
`ifdef BSG_FSB_TRAFFIC_NODE_LFSR_EN
          lfsr_d    = 16'hACE1;
`endif
        end
      end
      RUN: begin
        if ((num_q != '0) && (gov_count == num_q)) state_d = DONE;
      end
      default: ;
    endcase

    if (!en_i) state_d = IDLE;

    // Generator output is registered so v_o appears one cycle into RUN.
    gen_v_d = run && (state_d == RUN) && is_gen;
  end

  // The loopback FIFO only holds data while RUN persists.
  always_comb begin
    fifo_enq   = in_fire && is_loop;
    fifo_deq   = out_fire && is_loop;
    wr_ptr_d   = fifo_enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = fifo_deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({fifo_enq, fifo_deq})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: ;
    endcase
    if (state_d != RUN) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      state_q    <= IDLE;
      mode_q     <= 2'd0;
      num_q      <= '0;
      sent_q     <= '0;
      recv_q     <= '0;
      err_cnt_q  <= '0;
      error_q    <= 1'b0;
      seq_q      <= '0;
      gen_v_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
`ifdef BSG_FSB_TRAFFIC_NODE_LFSR_EN
      lfsr_q     <= 16'hACE1;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      num_q      <= num_d;
      sent_q     <= sent_d;
      recv_q     <= recv_d;
      err_cnt_q  <= err_cnt_d;
      error_q    <= error_d;
      seq_q      <= seq_d;
      gen_v_q    <= gen_v_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
`ifdef BSG_FSB_TRAFFIC_NODE_LFSR_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  // Storage needs no reset: it is only observed through a nonzero occupancy.
  always_ff @(posedge clk_i) begin
    if (fifo_enq) mem_q[wr_ptr_q] <= data_i;
  end

  assign sent_count_o  = sent_q;
  assign recv_count_o  = recv_q;
  assign error_count_o = err_cnt_q;
  assign error_o       = error_q;
  assign done_o        = (state_q == DONE);

endmodule

// File: tb/tb_bsg_fsb_traffic_node.sv
// Self-checking bench for bsg_fsb_traffic_node: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_bsg_fsb_traffic_node;

  localparam logic [3:0] CID = 4'h5;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [15:0] num_pkts_i = 16'd0;
  logic        v_i = 1'b0;
  logic [79:0] data_i = '0;
  logic        yumi_i = 1'b0;
  logic        ready_o, v_o, error_o, done_o;
  logic [79:0] data_o;
  logic [15:0] sent_count_o, recv_count_o, error_count_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  bsg_fsb_traffic_node #(
    .ring_width_p(80),
    .client_id_p(CID),
    .fifo_els_p(4),
    .pkt_count_width_p(16)
  ) dut (
    .clk_i(clk_i),
    .async_reset_n_i(rst_n),
    .en_i(en_i),
    .mode_i(mode_i),
    .num_pkts_i(num_pkts_i),
    .v_i(v_i),
    .data_i(data_i),
    .ready_o(ready_o),
    .v_o(v_o),
    .data_o(data_o),
    .yumi_i(yumi_i),
    .sent_count_o(sent_count_o),
    .recv_count_o(recv_count_o),
    .error_count_o(error_count_o),
    .error_o(error_o),
    .done_o(done_o)
  );

  // Reference model: phase 0 idle, 1 run, 2 done; loopback buffer as a queue.
  int          mphase = 0;
  logic [1:0]  mmode = 2'd0;
  logic [15:0] mnum = 16'd0;
  logic [15:0] msent = 16'd0;
  logic [15:0] mrecv = 16'd0;
  logic [15:0] merr = 16'd0;
  logic        merror = 1'b0;
  logic [15:0] mseq = 16'd0;
  bit          gen_live = 1'b0;
  logic [79:0] mq [$];
  bit          in_f, out_f;

  function automatic bit model_ready();
    return (mphase == 1) && ((mmode != 2'd1) || (mq.size() < 4));
  endfunction

  function automatic bit model_v();
    return (mphase == 1) && (((mmode == 2'd1) && (mq.size() > 0)) || ((mmode == 2'd2) && gen_live));
  endfunction

  function automatic logic [79:0] model_data();
    if (mmode == 2'd1) return mq[0];
    return {CID, 60'd0, mseq};
  endfunction

  function automatic logic [79:0] pkt(input int k);
    return 80'hBEEF_0123_4567_89AB_CDEF ^ 80'(k * 7 + 1);
  endfunction

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [1:0] m, input logic [15:0] n,
                               input logic v, input logic [79:0] d, input logic y);
    en_i = e;
    mode_i = m;
    num_pkts_i = n;
    v_i = v;
    data_i = d;
    yumi_i = y;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk_i or negedge rst_n);
      if (!rst_n) begin
        mphase = 0; mmode = 2'd0; mnum = 16'd0; msent = 16'd0; mrecv = 16'd0;
        merr = 16'd0; merror = 1'b0; mseq = 16'd0; gen_live = 1'b0; mq.delete();
      end else begin
        in_f  = v_i && model_ready();
        out_f = model_v() && yumi_i;
        if (mphase == 0) begin
          if (en_i && (mode_i != 2'd0)) begin
            mphase = 1; mmode = mode_i; mnum = num_pkts_i; msent = 16'd0; mrecv = 16'd0;
            merr = 16'd0; merror = 1'b0; mseq = 16'd0; gen_live = 1'b0;
          end
        end else if (mphase == 1) begin
          if (out_f) begin
            msent++;
            if (mmode == 2'd1) void'(mq.pop_front());
            else mseq++;
          end
          if (in_f) begin
            mrecv++;
            if (mmode == 2'd1) mq.push_back(data_i);
            else if (mmode == 2'd3) begin
              if (data_i[75:0] != {60'd0, mseq}) begin
                if (merr != 16'hFFFF) merr++;
                merror = 1'b1;
              end
              mseq++;
            end
          end
          gen_live = 1'b1;
          if ((mnum != 16'd0) && (((mmode == 2'd3) ? mrecv : msent) == mnum)) begin
            mphase = 2; mq.delete(); gen_live = 1'b0;
          end
        end
        if (!en_i) begin
          mphase = 0; mq.delete(); gen_live = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_n) begin
        checkOutput("ready_o", 80'(ready_o), 80'(model_ready()));
        checkOutput("v_o", 80'(v_o), 80'(model_v()));
        if (model_v()) checkOutput("data_o", data_o, model_data());
        checkOutput("sent_count_o", 80'(sent_count_o), 80'(msent));
        checkOutput("recv_count_o", 80'(recv_count_o), 80'(mrecv));
        checkOutput("error_count_o", 80'(error_count_o), 80'(merr));
        checkOutput("error_o", 80'(error_o), 80'(merror));
        checkOutput("done_o", 80'(done_o), 80'(mphase == 2));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  int          pl [5] = '{0, 1, 9, 3, 4};
  int          guard;
  logic [15:0] k16;
  logic        y;

  initial begin
    #1;
    checkOutput("rst_v_o", 80'(v_o), 80'd0);
    checkOutput("rst_data_o", data_o, 80'd0);
    checkOutput("rst_ready_o", 80'(ready_o), 80'd0);
    checkOutput("rst_sent", 80'(sent_count_o), 80'd0);
    checkOutput("rst_recv", 80'(recv_count_o), 80'd0);
    checkOutput("rst_errcnt", 80'(error_count_o), 80'd0);
    checkOutput("rst_done", 80'(done_o), 80'd0);
    #11 rst_n = 1'b1;
    @(posedge clk_i);
    #1;

    $display("[TB] generate 8 packets, yumi always high");
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 2'd2, 16'd8, 1'b0, '0, 1'b1);
      if (i == 1) checkOutput("gen_v_first_run_cycle", 80'(v_o), 80'd0);
      if (i == 2) checkOutput("gen_first_pkt", data_o, {CID, 76'd0});
      if (i == 3) checkOutput("gen_second_pkt", data_o, {CID, 76'd1});
      if (i == 9) begin
        checkOutput("gen_sent_c9", 80'(sent_count_o), 80'd7);
        checkOutput("gen_done_c9", 80'(done_o), 80'd0);
      end
      if (i == 10) begin
        checkOutput("gen_sent_c10", 80'(sent_count_o), 80'd8);
        checkOutput("gen_done_c10", 80'(done_o), 80'd1);
        checkOutput("gen_v_done", 80'(v_o), 80'd0);
      end
    end
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, '0, 1'b0);

    $display("[TB] check 5 packets with one bad payload");
    applyStimulus(1'b1, 2'd3, 16'd5, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd3, 16'd5, 1'b1, {CID, 76'(pl[i])}, 1'b0);
    checkOutput("chk_recv", 80'(recv_count_o), 80'd5);
    checkOutput("chk_errcnt", 80'(error_count_o), 80'd1);
    checkOutput("chk_error", 80'(error_o), 80'd1);
    checkOutput("chk_done", 80'(done_o), 80'd1);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, '0, 1'b0);

    $display("[TB] loopback fill with yumi low, then drain");
    applyStimulus(1'b1, 2'd1, 16'd0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd1, 16'd0, 1'b1, pkt(i), 1'b0);
    checkOutput("loop_full_ready", 80'(ready_o), 80'd0);
    checkOutput("loop_full_v", 80'(v_o), 80'd1);
    applyStimulus(1'b1, 2'd1, 16'd0, 1'b1, pkt(4), 1'b0);
    checkOutput("loop_full_recv", 80'(recv_count_o), 80'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("loop_echo", data_o, pkt(i));
      applyStimulus(1'b1, 2'd1, 16'd0, 1'b0, '0, 1'b1);
    end
    checkOutput("loop_drained_v", 80'(v_o), 80'd0);
    checkOutput("loop_sent", 80'(sent_count_o), 80'd4);

    $display("[TB] en_i dropped with two packets buffered");
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 2'd1, 16'd0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 2'd1, 16'd0, 1'b1, pkt(10), 1'b0);
    applyStimulus(1'b1, 2'd1, 16'd0, 1'b1, pkt(11), 1'b0);
    checkOutput("drop_v_before", 80'(v_o), 80'd1);
    applyStimulus(1'b0, 2'd1, 16'd0, 1'b0, '0, 1'b0);
    checkOutput("drop_v_after", 80'(v_o), 80'd0);
    checkOutput("drop_ready_after", 80'(ready_o), 80'd0);
    checkOutput("drop_recv_kept", 80'(recv_count_o), 80'd2);
    applyStimulus(1'b1, 2'd1, 16'd0, 1'b0, '0, 1'b0);
    checkOutput("reen_recv_clear", 80'(recv_count_o), 80'd0);
    checkOutput("reen_v_empty", 80'(v_o), 80'd0);
    checkOutput("reen_ready", 80'(ready_o), 80'd1);

    $display("[TB] generate 20 packets, random yumi");
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 2'd2, 16'd20, 1'b0, '0, 1'b0);
    k16 = 16'd0;
    guard = 0;
    while ((done_o !== 1'b1) && (guard < 400)) begin
      y = model_v() ? 1'($urandom_range(0, 1)) : 1'b0;
      if (v_o && y) begin
        checkOutput("gen_seq", data_o, {CID, 60'd0, k16});
        k16++;
      end
      applyStimulus(1'b1, 2'd2, 16'd20, 1'b0, '0, y);
      guard++;
    end
    checkOutput("gen_rand_done", 80'(done_o), 80'd1);
    checkOutput("gen_rand_count", 80'(k16), 80'd20);

    $display("[TB] asynchronous reset mid-generate");
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 2'd2, 16'd0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd2, 16'd0, 1'b0, '0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    en_i = 1'b0;
    yumi_i = 1'b0;
    checkOutput("arst_v_o", 80'(v_o), 80'd0);
    checkOutput("arst_data_o", data_o, 80'd0);
    checkOutput("arst_sent", 80'(sent_count_o), 80'd0);
    #3 rst_n = 1'b1;
    @(posedge clk_i);
    #1;

    $display("[TB] checker error counter saturation");
    applyStimulus(1'b1, 2'd3, 16'd0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 65538; i++) applyStimulus(1'b1, 2'd3, 16'd0, 1'b1, {CID, 76'h1_0000_0000}, 1'b0);
    checkOutput("sat_errcnt", 80'(error_count_o), 80'hFFFF);
    checkOutput("sat_recv_wrap", 80'(recv_count_o), 80'd2);
    checkOutput("sat_error", 80'(error_o), 80'd1);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
